// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler and its 4-bit ALU datapath.
package alu_sched_pkg;

  localparam int OPND_W = 4;
  localparam int OP_W   = 3;
  localparam int RES_W  = 8;

  localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB     = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL     = 3'b010;
  localparam logic [OP_W-1:0] OP_AND     = 3'b011;
  localparam logic [OP_W-1:0] OP_OR      = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR     = 3'b101;
  localparam logic [OP_W-1:0] OP_ERR_MIN = 3'b110;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } opnd_t;

  // Increment modulo n, for round-robin pointer advance.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid lane at or after ptr, wrapping modulo NUM_REQ.
module alu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   off;
  int                   sum;

  // Rotate so that bit 0 of rot is lane ptr; a priority search from bit 0 is then round-robin.
  assign dbl = {req_valid, req_valid} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    off       = 0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off       = i;
        any_valid = 1'b1;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    idx = ID_W'(sum);
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = any_valid && (idx == ID_W'(j));
    end
  end

endmodule

// File: rtl/simple_alu_4_bit.sv
// Combinational 4-bit ALU with 8-bit result; unsupported opcodes produce zero.
module simple_alu_4_bit
  import alu_sched_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [OP_W-1:0]   op_code,
  output logic [RES_W-1:0]  alu_out
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {{(RES_W-OPND_W){1'b0}}, a};
  assign b_ext = {{(RES_W-OPND_W){1'b0}}, b};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    alu_out = '0;
    case (op_code)
      OP_ADD:  alu_out = a_ext + b_ext;
      OP_SUB:  alu_out = a_ext - b_ext;
      OP_MUL:  alu_out = a_ext * b_ext;
      OP_AND:  alu_out = a_ext & b_ext;
      OP_OR:   alu_out = a_ext | b_ext;
      OP_XOR:  alu_out = a_ext ^ b_ext;
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one simple_alu_4_bit between NUM_REQ requesters.
// Optional per-lane saturating grant counters are enabled with `define ALU_GNT_CNT_EN.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic                      busy
`ifdef ALU_GNT_CNT_EN
  ,
  output logic [NUM_REQ*8-1:0]      gnt_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  opnd_t             opnd_q, opnd_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;
  logic [OPND_W-1:0]  sel_a;
  logic [OPND_W-1:0]  sel_b;
  logic [OP_W-1:0]    sel_op;
  logic [RES_W-1:0]   alu_out;

  alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  simple_alu_4_bit u_alu (
    .a       (opnd_q.a),
    .b       (opnd_q.b),
    .op_code (opnd_q.op),
    .alu_out (alu_out)
  );

  // A grant is only offered in IDLE and never while reset is held, so no request is consumed then lost.
  assign accept    = (state_q == IDLE) && pick_any && !rst;
  assign req_ready = accept ? pick_grant : '0;
  assign busy      = (state_q == EXEC) || (state_q == RESP);

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_a  = req_a[i*OPND_W +: OPND_W];
        sel_b  = req_b[i*OPND_W +: OPND_W];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opnd_d      = opnd_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          opnd_d  = '{a: sel_a, b: sel_b, op: sel_op};
          idx_d   = pick_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_id_d    = idx_q;
        rsp_err_d   = (opnd_q.op >= OP_ERR_MIN);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ID_W'(wrap_inc(32'(rsp_id_q), NUM_REQ));
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // NOTE: the operand register needs no reset; it is always written in IDLE before EXEC reads it.
  always_ff @(posedge clk) begin
    opnd_q <= opnd_d;
    idx_q  <= idx_d;
  end

`ifdef ALU_GNT_CNT_EN
  logic [7:0] cnt_q [NUM_REQ];
  logic [7:0] cnt_d [NUM_REQ];

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (pick_idx == ID_W'(i)) && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i*8 +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after it.
module tb_alu_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*4-1:0] req_a;
  logic [NUM_REQ*4-1:0] req_b;
  logic [NUM_REQ*3-1:0] req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_err;
  logic                 busy;
`ifdef ALU_GNT_CNT_EN
  logic [NUM_REQ*8-1:0] gnt_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef ALU_GNT_CNT_EN
    ,
    .gnt_cnt   (gnt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction on a single lane with rsp_ready high: accept, EXEC, RESP.
  task automatic run_txn(input int lane, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic [7:0] exp_d, input logic exp_e,
                         input string tag);
    @(negedge clk);
    req_valid            = '0;
    req_valid[lane]      = 1'b1;
    req_a[lane*4 +: 4]   = a;
    req_b[lane*4 +: 4]   = b;
    req_op[lane*3 +: 3]  = op;
    #1 check($sformatf("%s_gnt", tag), 32'(req_ready), 32'(1 << lane));
    @(negedge clk);
    check($sformatf("%s_exec_busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s_exec_vld", tag), 32'(rsp_valid), 32'd0);
    check($sformatf("%s_exec_rdy", tag), 32'(req_ready), 32'd0);
    req_valid[lane]     = 1'b0;
    req_a[lane*4 +: 4]  = ~a;
    req_b[lane*4 +: 4]  = ~b;
    req_op[lane*3 +: 3] = ~op;
    @(negedge clk);
    check($sformatf("%s_vld", tag), 32'(rsp_valid), 32'd1);
    check($sformatf("%s_data", tag), 32'(rsp_data), 32'(exp_d));
    check($sformatf("%s_id", tag), 32'(rsp_id), 32'(lane));
    check($sformatf("%s_err", tag), 32'(rsp_err), 32'(exp_e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp1 [6];
    logic [7:0] exp2 [6];
    exp1 = '{8'd4, 8'hFE, 8'd3, 8'd1, 8'd3, 8'd2};
    exp2 = '{8'd11, 8'd5, 8'd24, 8'd0, 8'd11, 8'd11};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("idle_no_req_rdy", 32'(req_ready), 32'd0);

    // Lane 0, A=1 B=3, every defined op.
    for (int op = 0; op < 6; op++)
      run_txn(0, 4'b0001, 4'b0011, 3'(op), exp1[op], 1'b0, $sformatf("l0_op%0d", op));

    // Lane 2, A=8 B=3, every defined op.
    for (int op = 0; op < 6; op++)
      run_txn(2, 4'b1000, 4'b0011, 3'(op), exp2[op], 1'b0, $sformatf("l2_op%0d", op));

    // Operand extremes.
    run_txn(3, 4'hF, 4'hF, 3'b010, 8'hE1, 1'b0, "mul_max");
    run_txn(1, 4'h0, 4'hF, 3'b001, 8'hF1, 1'b0, "sub_min");
    run_txn(3, 4'hF, 4'hF, 3'b000, 8'h1E, 1'b0, "add_max");

    // Illegal opcodes, then a legal one clears the error flag.
    run_txn(0, 4'h5, 4'h5, 3'b111, 8'h00, 1'b1, "op111");
    run_txn(0, 4'h5, 4'h5, 3'b000, 8'h0A, 1'b0, "op000_after_err");
    run_txn(2, 4'hF, 4'hF, 3'b110, 8'h00, 1'b1, "op110");

    // All lanes continuously valid from ptr=0: grant order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*4 +: 4]  = 4'(i);
      req_b[i*4 +: 4]  = 4'd1;
      req_op[i*3 +: 3] = 3'b000;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr%0d_gnt", k), 32'(req_ready), 32'(1 << (k % NUM_REQ)));
      @(negedge clk);
      check($sformatf("rr%0d_busy", k), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % NUM_REQ));
      check($sformatf("rr%0d_data", k), 32'(rsp_data), 32'((k % NUM_REQ) + 1));
      if (k == 4) req_valid = '0;
      @(negedge clk);
    end

    // Backpressure: hold rsp_ready low 5 cycles in RESP with other lanes waiting.
    rsp_ready    = 1'b0;
    req_valid    = 4'b0010;
    req_a[7:4]   = 4'hF;
    req_b[7:4]   = 4'h2;
    req_op[5:3]  = 3'b001;
    #1 check("hold_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1001;
    #1 check("hold_exec_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("hold_vld0", 32'(rsp_valid), 32'd1);
    check("hold_data0", 32'(rsp_data), 32'h0D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_vld", c), 32'(rsp_valid), 32'd1);
      check($sformatf("hold%0d_data", c), 32'(rsp_data), 32'h0D);
      check($sformatf("hold%0d_id", c), 32'(rsp_id), 32'd1);
      check($sformatf("hold%0d_err", c), 32'(rsp_err), 32'd0);
      check($sformatf("hold%0d_rdy", c), 32'(req_ready), 32'd0);
      check($sformatf("hold%0d_busy", c), 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_vld", 32'(rsp_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    // ptr is now 2: lanes 0 and 3 waiting, lane 3 comes first.
    check("release_gnt", 32'(req_ready), 32'b1000);
    req_valid = '0;
    @(negedge clk);
    check("dropped_req_idle", 32'(busy), 32'd0);

    // Reset while in EXEC: result discarded and ptr returns to 0.
    run_txn(2, 4'h1, 4'h1, 3'b000, 8'h02, 1'b0, "pre_rst");
    @(negedge clk);
    req_valid   = 4'b0010;
    req_a[7:4]  = 4'h3;
    req_b[7:4]  = 4'h3;
    req_op[5:3] = 3'b000;
    #1 check("rst_exec_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("rst_exec_busy", 32'(busy), 32'd1);
    rst       = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("rst_exec_vld", 32'(rsp_valid), 32'd0);
    check("rst_exec_idle", 32'(busy), 32'd0);
    check("rst_exec_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("rst_exec_ptr0", 32'(req_ready), 32'b0010);
    req_valid = '0;
    @(negedge clk);
    check("rst_exec_vld_after", 32'(rsp_valid), 32'd0);

`ifdef ALU_GNT_CNT_EN
    check("cnt_clear", gnt_cnt, 32'd0);
    for (int n = 0; n < 300; n++)
      run_txn(0, 4'h1, 4'h1, 3'b000, 8'h02, 1'b0, "sat");
    @(negedge clk);
    check("cnt_sat", gnt_cnt, 32'h0000_00FF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
